// File: rtl/ps2_kbd_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_kbd_ctrl
//
// PS/2 keyboard front end. The raw PS/2 clock and data pins are synchronised
// into the clk domain. 11-bit frames (start, 8 data LSB first, odd parity,
// stop) are received on falling ps2_clk edges, guarded by an inactivity
// watchdog. The F0 (break) and E0 (extended) prefixes are folded into flags
// on the following key byte. Shift/ctrl state is tracked. Decoded key events
// are queued in a first-word-fall-through FIFO for the downstream consumer.
//
// Parameters
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW entries
//   TIMEOUT_CYC  clk cycles without a falling ps2_clk edge before a partial
//                frame is abandoned
//
// Ports
//   clk         in   system clock, rising edge
//   clrn        in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   rd_en       in   pop the head entry when valid=1
//   valid       out  FIFO non-empty
//   code        out  head scan code (prefix bytes removed), 0 when empty
//   brk         out  head entry is a break (release), 0 when empty
//   ext         out  head entry was E0-prefixed, 0 when empty
//   shift_held  out  left (12) or right (59) shift currently held
//   ctrl_held   out  ctrl (14 or E0 14) currently held
//   overflow    out  sticky: an event was dropped because the FIFO was full
//   frame_err   out  one-cycle pulse on start, parity, stop or timeout error
//
// Build option
//   PS2_TYPEMATIC_FILTER_EN  when defined, a repeated make of the most
//                            recently pushed key is dropped until that key
//                            is released (auto-repeat suppression).
// -----------------------------------------------------------------------------
module ps2_kbd_ctrl #(
   parameter int FIFO_AW     = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic       valid,
   output logic [7:0] code,
   output logic       brk,
   output logic       ext,
   output logic       shift_held,
   output logic       ctrl_held,
   output logic       overflow,
   output logic       frame_err
);

   localparam int            DEPTH    = 2 ** FIFO_AW;
   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchroniser: stage p0/p1 are the two-flop synchroniser, p2 only
   // delays the clock so a falling edge can be seen as p2=1, p1=0.
   // ---------------------------------------------------------------------------
   logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
   logic ps2_data_p0, ps2_data_p1;
   logic fall;
   logic bit_in;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ps2_clk_p0  <= 1'b0;
         ps2_clk_p1  <= 1'b0;
         ps2_clk_p2  <= 1'b0;
         ps2_data_p0 <= 1'b0;
         ps2_data_p1 <= 1'b0;
      end else begin
         ps2_clk_p0  <= ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_clk_p2  <= ps2_clk_p1;
         ps2_data_p0 <= ps2_data;
         ps2_data_p1 <= ps2_data_p0;
      end
   end

   assign fall   = ps2_clk_p2 & ~ps2_clk_p1;
   assign bit_in = ps2_data_p1;

   // ---------------------------------------------------------------------------
   // Frame reception FSM
   // ---------------------------------------------------------------------------
   state_t        state, state_nx;
   logic          err_nx;
   logic          frame_ok;
   logic [9:0]    shreg;      // after a full frame: [9]=stop, [8]=parity, [7:0]=data
   logic [3:0]    bit_cnt;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= S_IDLE;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         frame_err <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      frame_ok = 1'b0;
      case (state)
         S_IDLE: begin
            if (fall) begin
               if (!bit_in) state_nx = S_RECV;
               else         err_nx   = 1'b1;   // start bit must be 0
            end
         end
         S_RECV: begin
            if (fall) begin
               if (bit_cnt == 4'd9) state_nx = S_CHECK;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nx = S_IDLE;
               err_nx   = 1'b1;
            end
         end
         S_CHECK: begin
            state_nx = S_IDLE;
            // odd parity over data+parity, stop bit high
            if ((^shreg[8:0]) && shreg[9]) frame_ok = 1'b1;
            else                           err_nx   = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Shift register, bit counter and watchdog follow the FSM state.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         shreg   <= '0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         if (state == S_IDLE) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
         end else if (state == S_RECV) begin
            if (fall) begin
               shreg   <= {bit_in, shreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Byte decode: prefix folding, modifier tracking, push request
   // ---------------------------------------------------------------------------
   logic [7:0] rx_byte;
   logic       is_f0, is_e0;
   logic       evt_req;
   logic       push_req;
   logic       brk_pend, ext_pend;
   logic       shift_l, shift_r, ctrl_st;

   assign rx_byte = shreg[7:0];
   assign is_f0   = (rx_byte == 8'hF0);
   assign is_e0   = (rx_byte == 8'hE0);
   assign evt_req = frame_ok && !is_f0 && !is_e0;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         brk_pend <= 1'b0;
         ext_pend <= 1'b0;
      end else if (frame_ok) begin
         if (is_f0) begin
            brk_pend <= 1'b1;
         end else if (is_e0) begin
            ext_pend <= 1'b1;
         end else begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
         end
      end
   end

   // Modifier state follows every key event, including events the FIFO or
   // the repeat filter later drops.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         shift_l <= 1'b0;
         shift_r <= 1'b0;
         ctrl_st <= 1'b0;
      end else if (evt_req) begin
         if (!ext_pend && rx_byte == 8'h12) shift_l <= !brk_pend;
         if (!ext_pend && rx_byte == 8'h59) shift_r <= !brk_pend;
         if (rx_byte == 8'h14)              ctrl_st <= !brk_pend;
      end
   end

   assign shift_held = shift_l | shift_r;
   assign ctrl_held  = ctrl_st;

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       hold_vld;
   logic [8:0] hold_key;       // {ext, code} of the last pushed make
   logic       rep_drop;

   assign rep_drop = evt_req && !brk_pend && hold_vld &&
                     (hold_key == {ext_pend, rx_byte});
   assign push_req = evt_req && !rep_drop;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         hold_vld <= 1'b0;
         hold_key <= '0;
      end else if (evt_req) begin
         if (!brk_pend) begin
            hold_vld <= 1'b1;
            hold_key <= {ext_pend, rx_byte};
         end else if (hold_key == {ext_pend, rx_byte}) begin
            hold_vld <= 1'b0;
         end
      end
   end
`else
   assign push_req = evt_req;
`endif

   // ---------------------------------------------------------------------------
   // Event FIFO (first-word-fall-through). Pointers carry an extra MSB so
   // full and empty can be told apart when the index bits match.
   // ---------------------------------------------------------------------------
   logic [9:0]       mem [DEPTH];  // {ext, brk, code}
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             empty, full;
   logic             do_pop, do_push;
   logic [9:0]       head;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign do_pop  = rd_en && !empty;
   // a pop frees a slot in the same cycle, so a push into a full FIFO
   // still lands when the consumer reads simultaneously
   assign do_push = push_req && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= {ext_pend, brk_pend, rx_byte};
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push)                    wr_ptr   <= wr_ptr + 1'b1;
         if (do_pop)                     rd_ptr   <= rd_ptr + 1'b1;
         if (push_req && full && !do_pop) overflow <= 1'b1;
      end
   end

   assign head  = mem[rd_ptr[FIFO_AW-1:0]];
   assign valid = !empty;
   assign code  = valid ? head[7:0] : 8'h00;
   assign brk   = valid ? head[8]   : 1'b0;
   assign ext   = valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

   localparam int HALF = 8;     // clk cycles per PS/2 clock half period
   localparam int TMO  = 300;   // shortened watchdog for simulation

   logic       clk = 1'b0;
   logic       clrn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic       rd_auto;
   logic       rd_man;
   logic       valid;
   logic [7:0] code;
   logic       brk;
   logic       ext;
   logic       shift_held;
   logic       ctrl_held;
   logic       overflow;
   logic       frame_err;

   int         checks   = 0;
   int         errors   = 0;
   int         ferr_cnt = 0;
   bit         auto_pop = 1'b1;
   logic [9:0] exp_q[$];        // expected {ext, brk, code}

   assign rd_en = rd_auto | rd_man;

   ps2_kbd_ctrl #(
      .FIFO_AW    (3),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .valid     (valid),
      .code      (code),
      .brk       (brk),
      .ext       (ext),
      .shift_held(shift_held),
      .ctrl_held (ctrl_held),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // frame_err high cycles
   always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

   // Scoreboard monitor: decides auto pops at the falling edge and checks
   // every entry the DUT gives up against the expected queue.
   initial begin
      logic [9:0] e;
      rd_auto = 1'b0;
      forever begin
         @(negedge clk);
         rd_auto = auto_pop & valid;
         #2;
         if (rd_en && valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got %0h, expected no entry", {ext, brk, code});
            end else begin
               e = exp_q.pop_front();
               chk("pop_entry", {22'd0, ext, brk, code}, {22'd0, e});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
      return {stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic expect_evt(input logic e, input logic b, input logic [7:0] c);
      exp_q.push_back({e, b, c});
   endtask

   // mode 0: plain; 1: manual pop during the CHECK cycle of the last bit;
   // 2: latency check around the last bit (expects entry 1C make)
   task automatic send_bits(input logic [10:0] bits, input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == n - 1 && mode == 1) begin
            repeat (3) @(negedge clk);
            rd_man = 1'b1;
            @(negedge clk);
            rd_man = 1'b0;
            repeat (HALF - 4) @(negedge clk);
         end else if (i == n - 1 && mode == 2) begin
            repeat (3) @(negedge clk);
            chk("lat_valid_early", valid, 0);
            @(negedge clk);
            chk("lat_valid_on_time", valid, 1);
            chk("lat_code", code, 8'h1C);
            chk("lat_brk_ext", {brk, ext}, 0);
            @(negedge clk);
            chk("lat_valid_after_pop", valid, 0);
            repeat (HALF - 5) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b);
      send_bits(frame(b, 1'b0, 1'b1), 11, 0);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      int          f0;
      logic [7:0]  codes [9];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

      clrn     = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd_man   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_code", code, 0);
      chk("rst_brk_ext", {brk, ext}, 0);
      chk("rst_mods", {shift_held, ctrl_held}, 0);
      chk("rst_ovf_err", {overflow, frame_err}, 0);
      clrn = 1'b1;
      repeat (5) @(negedge clk);

      // single make with latency measurement
      expect_evt(1'b0, 1'b0, 8'h1C);
      send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 2);

      // prefix folding
      expect_evt(1'b0, 1'b1, 8'h1C);
      send_frame(8'hF0); send_frame(8'h1C);
      expect_evt(1'b1, 1'b1, 8'h75);
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      wait_drain("drain_prefix");

      // modifiers
      expect_evt(1'b0, 1'b0, 8'h12); send_frame(8'h12);
      chk("shift_after_12", shift_held, 1);
      expect_evt(1'b0, 1'b0, 8'h59); send_frame(8'h59);
      chk("shift_after_59", shift_held, 1);
      expect_evt(1'b0, 1'b1, 8'h12); send_frame(8'hF0); send_frame(8'h12);
      chk("shift_after_brk12", shift_held, 1);
      expect_evt(1'b0, 1'b1, 8'h59); send_frame(8'hF0); send_frame(8'h59);
      chk("shift_after_brk59", shift_held, 0);
      expect_evt(1'b1, 1'b0, 8'h14); send_frame(8'hE0); send_frame(8'h14);
      chk("ctrl_after_e014", ctrl_held, 1);
      expect_evt(1'b1, 1'b1, 8'h14); send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h14);
      chk("ctrl_after_brk", ctrl_held, 0);
      wait_drain("drain_mods");

      // frame errors
      f0 = ferr_cnt;
      send_bits(frame(8'h1C, 1'b1, 1'b1), 11, 0);
      chk("parity_err_pulse", ferr_cnt - f0, 1);
      chk("parity_no_push", valid, 0);
      f0 = ferr_cnt;
      send_bits(frame(8'h1C, 1'b0, 1'b0), 11, 0);
      chk("stop_err_pulse", ferr_cnt - f0, 1);
      f0 = ferr_cnt;
      send_bits(11'h7FF, 1, 0);
      chk("start_err_pulse", ferr_cnt - f0, 1);

      // watchdog on a truncated frame
      f0 = ferr_cnt;
      send_bits(frame(8'h2B, 1'b0, 1'b1), 4, 0);
      repeat (TMO - 50) @(negedge clk);
      chk("tmo_not_early", ferr_cnt - f0, 0);
      repeat (100) @(negedge clk);
      chk("tmo_err_pulse", ferr_cnt - f0, 1);
      expect_evt(1'b0, 1'b0, 8'h2B); send_frame(8'h2B);
      wait_drain("drain_tmo");

      // overflow: 9 pushes, no reads
      auto_pop = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_evt(1'b0, 1'b0, codes[i]);
         send_frame(codes[i]);
      end
      chk("ovf_valid", valid, 1);
      chk("ovf_set", overflow, 1);
      auto_pop = 1'b1;
      wait_drain("drain_ovf");
      chk("ovf_sticky", overflow, 1);

      // reset in the middle of a frame
      expect_evt(1'b0, 1'b0, 8'h12); send_frame(8'h12);
      wait_drain("drain_pre_rst");
      auto_pop = 1'b0;
      send_frame(8'h1C);
      chk("pre_rst_valid", valid, 1);
      send_bits(frame(8'h33, 1'b0, 1'b1), 5, 0);
      clrn = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_code", code, 0);
      chk("mid_rst_mods", {shift_held, ctrl_held}, 0);
      chk("mid_rst_ovf", overflow, 0);
      f0 = ferr_cnt;
      clrn = 1'b1;
      repeat (TMO + 50) @(negedge clk);
      chk("mid_rst_silent", ferr_cnt - f0, 0);

      // full FIFO with push and pop in the same cycle
      for (int i = 0; i < 8; i++) begin
         expect_evt(1'b0, 1'b0, codes[i]);
         send_frame(codes[i]);
      end
      expect_evt(1'b0, 1'b0, codes[8]);
      send_bits(frame(codes[8], 1'b0, 1'b1), 11, 1);
      chk("full_pushpop_ovf", overflow, 0);
      chk("full_pushpop_valid", valid, 1);
      auto_pop = 1'b1;
      wait_drain("drain_full");

      // typematic repeat
      for (int i = 0; i < 3; i++) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
         if (i == 0) expect_evt(1'b0, 1'b0, 8'h1C);
`else
         expect_evt(1'b0, 1'b0, 8'h1C);
`endif
         send_frame(8'h1C);
      end
      expect_evt(1'b0, 1'b1, 8'h1C);
      send_frame(8'hF0); send_frame(8'h1C);
      wait_drain("drain_repeat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Front-end controller for the keyboard datapath. It samples the raw PS/2 clock and data lines in the system clock domain and sequences 11-bit frame reception with start, parity and stop checks plus a watchdog. It folds the F0 (break) and E0 (extended) prefixes into flags and tracks shift/ctrl state. Decoded key events are queued in a FIFO; the downstream scan-code-to-ASCII translator and the text buffer pop them with a valid/rd_en handshake.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries
TIMEOUT_CYC, 50000, clk cycles without a falling ps2_clk edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
clrn  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
rd_en  input  1  consumer pops head entry when valid=1
valid  output  1  FIFO non-empty; head entry on code/brk/ext
code  output  8  head scan code (prefix bytes removed)
brk  output  1  head entry is a break (release)
ext  output  1  head entry was E0-prefixed
shift_held  output  1  left (12) or right (59) shift currently held
ctrl_held  output  1  ctrl (14 or E0 14) currently held
overflow  output  1  sticky: event dropped because FIFO was full
frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Reset (clrn=0, async): FSM to IDLE; FIFO emptied; all outputs 0; pending prefix flags, modifier state and sync flops cleared.
- Sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is detected when the 3rd-stage ps2_clk is 1 and the 2nd-stage value is 0. Data is sampled from its 2nd-stage flop in the same cycle.
- FSM states:
  - IDLE: falling edge with data=0 -> RECV, bit count 0. Falling edge with data=1 (bad start) -> frame_err pulse, stay IDLE.
  - RECV: shift 8 data bits LSB first, then the parity bit, then the stop bit, one per falling edge. After the stop bit -> CHECK.
  - RECV timeout: the idle counter resets on each edge; if it reaches TIMEOUT_CYC -> IDLE with a frame_err pulse and the partial frame discarded.
  - CHECK (1 cycle): valid frame requires odd parity over data+parity and stop=1. On error: frame_err pulse and discard. Either way -> IDLE.
- Byte handling in CHECK, valid frames:
  - F0: set brk_pend, no push.
  - E0: set ext_pend, no push.
  - Any other byte: push {ext_pend, brk_pend, byte}, then clear both pending flags.
  - Modifier update happens with the push. 12/59 (ext_pend=0) set or clear the left/right shift bit; 14 (either ext) sets or clears the ctrl bit. Modifier bytes are also pushed.
- Latency: valid rises exactly 2 clk cycles after the cycle the stop-bit edge is detected (CHECK cycle, then write).
- FIFO: first-word-fall-through; code/brk/ext always show the head entry and are 0 when empty.
  - Pop: rd_en=1 while valid=1. rd_en while empty is ignored.
  - Push while full with no pop: event dropped, overflow set; overflow stays set until reset.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push into empty FIFO with rd_en high in the same cycle: push only.
  - Pointers wrap modulo depth; full/empty use an extra MSB on each pointer.
- Reset mid-frame aborts the frame silently, with no frame_err pulse.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined: holds the last pushed make {ext,code}. A further make of the same key before its break is dropped, which suppresses auto-repeat. A break of that key clears the holder. Modifier tracking still updates on dropped makes.
- Undefined: every make is pushed, so auto-repeat yields repeated entries.

Test Plan:
- Frame 1C (A), parity 0, stop 1 -> valid rises 2 cycles after the stop edge; code=1C, brk=0, ext=0; rd_en pulse -> valid=0.
- Sequence F0,1C -> exactly one entry {code=1C, brk=1, ext=0}. Sequence E0,F0,75 -> one entry {75, brk=1, ext=1}.
- Make 12, then 59, then break 12 -> shift_held 1,1,1; then break 59 -> 0. E0 14 -> ctrl_held=1; E0 F0 14 -> 0.
- Frame 1C with bad parity bit -> frame_err one-cycle pulse, no push. Frame stopped after 4 bits -> frame_err at TIMEOUT_CYC, next good frame 2B decoded correctly.
- Push 9 makes with no reads (depth 8) -> 8 entries, overflow=1. A 9th push coinciding with rd_en while full -> accepted, overflow stays 0. Reset mid-frame -> all outputs 0.
- Filter on: make 1C x3 then break 1C -> 2 entries (1C make, 1C break). Filter off -> 4 entries.
